// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU in-flight instruction controller.
package fir_xifu_pkg;

  localparam int FIR_XIFU_NREGS = 32;
  // Widest supported ID_WIDTH; narrower IDs are zero-extended into the entry.
  localparam int FIR_XIFU_ID_W  = 8;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2,
    KILLED    = 2'd3
  } fir_xifu_ctrl_state_e;

  typedef struct packed {
    fir_xifu_ctrl_state_e     state;
    logic [FIR_XIFU_ID_W-1:0] id;
    logic [4:0]               rd;
    logic                     we;
  } fir_xifu_ctrl_entry_t;

  localparam fir_xifu_ctrl_entry_t FIR_XIFU_ENTRY_RST =
    '{state: FREE, id: '0, rd: '0, we: 1'b0};

endpackage

// File: rtl/fir_xifu_ctrl_slot.sv
// One in-flight entry: lifecycle state machine plus commit/retire/query ID matching.
module fir_xifu_ctrl_slot
  import fir_xifu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     alloc_i,
  input  fir_xifu_ctrl_entry_t     alloc_entry_i,
  input  logic                     commit_valid_i,
  input  logic [FIR_XIFU_ID_W-1:0] commit_id_i,
  input  logic                     commit_kill_i,
  input  logic                     retire_valid_i,
  input  logic [FIR_XIFU_ID_W-1:0] retire_id_i,
  input  logic [FIR_XIFU_ID_W-1:0] query_id_i,
  output fir_xifu_ctrl_entry_t     entry_o,
  output logic                     retire_hit_o,
  output logic                     query_committed_o,
  output logic                     query_killed_o,
  output logic                     kill_o
);

  fir_xifu_ctrl_entry_t entry_q, entry_d;
  logic commit_hit, retire_hit, query_hit;

  always_comb begin
    commit_hit = commit_valid_i && (entry_q.state == ISSUED) && (entry_q.id == commit_id_i);
    retire_hit = retire_valid_i && ((entry_q.state == COMMITTED) || (entry_q.state == KILLED))
                 && (entry_q.id == retire_id_i);
    query_hit  = (entry_q.state != FREE) && (entry_q.id == query_id_i);

    entry_d = entry_q;
    if (clear_i)         entry_d.state = FREE;
    else if (alloc_i)    entry_d = alloc_entry_i;  // only ever raised on a FREE slot
    else if (commit_hit) entry_d.state = commit_kill_i ? KILLED : COMMITTED;
    else if (retire_hit) entry_d.state = FREE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) entry_q <= FIR_XIFU_ENTRY_RST;
    else       entry_q <= entry_d;
  end

  assign entry_o           = entry_q;
  assign retire_hit_o      = retire_hit;
  assign query_committed_o = query_hit && (entry_q.state == COMMITTED);
  assign query_killed_o    = query_hit && (entry_q.state == KILLED);
  assign kill_o            = (entry_d.state == KILLED) && (entry_q.state != KILLED);

endmodule

// File: rtl/fir_xifu_ctrl.sv
// FIR XIFU in-flight instruction controller: allocation, RAW/WAW scoreboard, commit/kill tracking.
// Optional performance counters are built when FIR_XIFU_CTRL_PERF_EN is defined.
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_accept_i,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  input  logic [4:0]            issue_rd_i,
  input  logic                  issue_we_i,
  output logic                  issue_ready_o,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  retire_valid_i,
  input  logic [ID_WIDTH-1:0]   retire_id_i,
  input  logic [ID_WIDTH-1:0]   query_id_i,
  output logic                  query_committed_o,
  output logic                  query_killed_o,
  output logic                  busy_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef FIR_XIFU_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [15:0]           kill_count_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fir_xifu_ctrl_entry_t [DEPTH-1:0] ent;
  fir_xifu_ctrl_entry_t             alloc_entry;
  logic [DEPTH-1:0] alloc_oh, slot_retire_hit, slot_q_com, slot_q_kill, slot_kill;
  logic [FIR_XIFU_ID_W-1:0] commit_id_x, retire_id_x, query_id_x;
  logic [FIR_XIFU_NREGS-1:0] pend;
  logic [CW-1:0] count;
  logic issue_fire, alloc_found, id_dup;

  assign commit_id_x = FIR_XIFU_ID_W'(commit_id_i);
  assign retire_id_x = FIR_XIFU_ID_W'(retire_id_i);
  assign query_id_x  = FIR_XIFU_ID_W'(query_id_i);

  // Occupancy, scoreboard and lowest-free pick all come from registered slot state.
  always_comb begin
    count       = '0;
    pend        = '0;
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[i].state != FREE) count = count + CW'(1);
      if (ent[i].we && ((ent[i].state == ISSUED) || (ent[i].state == COMMITTED)))
        pend[ent[i].rd] = 1'b1;
      if ((ent[i].state == FREE) && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  assign issue_ready_o = (count < CW'(DEPTH)) && !pend[issue_rs1_i] && !pend[issue_rs2_i]
                         && !(issue_we_i && pend[issue_rd_i]);
  assign issue_fire    = issue_valid_i && issue_accept_i && issue_ready_o;

  always_comb begin
    alloc_entry = '{state: ISSUED, id: FIR_XIFU_ID_W'(issue_id_i), rd: issue_rd_i, we: issue_we_i};
    if (commit_valid_i && (commit_id_i == issue_id_i))
      alloc_entry.state = commit_kill_i ? KILLED : COMMITTED;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    fir_xifu_ctrl_slot u_slot (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .clear_i           (clear_i),
      .alloc_i           (alloc_oh[g] && issue_fire),
      .alloc_entry_i     (alloc_entry),
      .commit_valid_i    (commit_valid_i),
      .commit_id_i       (commit_id_x),
      .commit_kill_i     (commit_kill_i),
      .retire_valid_i    (retire_valid_i),
      .retire_id_i       (retire_id_x),
      .query_id_i        (query_id_x),
      .entry_o           (ent[g]),
      .retire_hit_o      (slot_retire_hit[g]),
      .query_committed_o (slot_q_com[g]),
      .query_killed_o    (slot_q_kill[g]),
      .kill_o            (slot_kill[g])
    );
  end

  assign query_committed_o = |slot_q_com;
  assign query_killed_o    = |slot_q_kill;
  assign busy_o            = (count != '0);
  assign count_o           = count;

  always_comb begin
    id_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if ((ent[i].state != FREE) && (ent[j].state != FREE) && (ent[i].id == ent[j].id))
          id_dup = 1'b1;
  end

  a_retire_known: assert property (@(posedge clk_i) disable iff (rst_i)
    retire_valid_i |-> |slot_retire_hit);
  a_id_unique: assert property (@(posedge clk_i) disable iff (rst_i) !id_dup);

`ifdef FIR_XIFU_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] kill_count_q, kill_count_d;

  // Saturating counters; clear_i deliberately leaves them alone.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    kill_count_d   = kill_count_q;
    if (issue_valid_i && issue_accept_i && !issue_ready_o && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if ((|slot_kill) && (kill_count_q != '1))
      kill_count_d = kill_count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      kill_count_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      kill_count_q   <= kill_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign kill_count_o   = kill_count_q;
`else
  logic unused_kill;
  assign unused_kill = ^slot_kill;
`endif

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed self-checking bench for fir_xifu_ctrl (DEPTH=4, ID_WIDTH=4).
module tb_fir_xifu_ctrl;

  logic       clk = 1'b0;
  logic       rst_i, clear_i;
  logic       issue_valid_i, issue_accept_i, issue_we_i;
  logic [3:0] issue_id_i, commit_id_i, retire_id_i, query_id_i;
  logic [4:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic       commit_valid_i, commit_kill_i, retire_valid_i;
  logic       issue_ready_o, query_committed_o, query_killed_o, busy_o;
  logic [2:0] count_o;
`ifdef FIR_XIFU_CTRL_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [15:0] kill_count_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_xifu_ctrl #(.DEPTH(4), .ID_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .issue_valid_i(issue_valid_i), .issue_accept_i(issue_accept_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
    .issue_we_i(issue_we_i), .issue_ready_o(issue_ready_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i), .query_id_i(query_id_i),
    .query_committed_o(query_committed_o), .query_killed_o(query_killed_o),
    .busy_o(busy_o), .count_o(count_o)
`ifdef FIR_XIFU_CTRL_PERF_EN
    , .stall_cycles_o(stall_cycles_o), .kill_count_o(kill_count_o)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    clear_i = 0; issue_valid_i = 0; issue_accept_i = 0; issue_we_i = 0;
    issue_id_i = 0; issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
    commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
    retire_valid_i = 0; retire_id_i = 0; query_id_i = 0;
  endtask

  task automatic set_issue(input logic [3:0] id, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we);
    issue_valid_i = 1; issue_accept_i = 1; issue_id_i = id;
    issue_rs1_i = rs1; issue_rs2_i = rs2; issue_rd_i = rd; issue_we_i = we;
  endtask

  task automatic do_issue(input logic [3:0] id, input logic [4:0] rd, input logic we);
    set_issue(id, 5'd0, 5'd0, rd, we); tick(); idle();
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1; commit_id_i = id; commit_kill_i = kill; tick(); idle();
  endtask

  task automatic do_retire(input logic [3:0] id);
    retire_valid_i = 1; retire_id_i = id; tick(); idle();
  endtask

  task automatic do_clear();
    clear_i = 1; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst_i = 1; tick(); tick(); rst_i = 0; #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", issue_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
    total++; if ({query_committed_o, query_killed_o} !== 2'b00) begin bad++; $display("FAIL reset_query got=%b want=00", {query_committed_o, query_killed_o}); end
`ifdef FIR_XIFU_CTRL_PERF_EN
    total++; if (kill_count_o !== 16'd0 || stall_cycles_o !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", stall_cycles_o, kill_count_o); end
`endif
  endtask

  task automatic test_basic();
    do_issue(4'd3, 5'd5, 1'b1);
    total++; if (count_o !== 3'd1 || busy_o !== 1'b1) begin bad++; $display("FAIL basic_count got=%0d/%b want=1/1", count_o, busy_o); end
    issue_rs1_i = 5'd5; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL basic_pend5 got=%b want=0", issue_ready_o); end
    issue_rs1_i = 5'd6; query_id_i = 4'd3; #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL basic_nopend6 got=%b want=1", issue_ready_o); end
    total++; if ({query_committed_o, query_killed_o} !== 2'b00) begin bad++; $display("FAIL basic_query_issued got=%b want=00", {query_committed_o, query_killed_o}); end
    do_commit(4'd3, 1'b0);
    query_id_i = 4'd3; #1;
    total++; if ({query_committed_o, query_killed_o} !== 2'b10) begin bad++; $display("FAIL basic_query_committed got=%b want=10", {query_committed_o, query_killed_o}); end
    query_id_i = 4'd9; #1;
    total++; if ({query_committed_o, query_killed_o} !== 2'b00) begin bad++; $display("FAIL basic_query_unmatched got=%b want=00", {query_committed_o, query_killed_o}); end
    do_retire(4'd3);
    issue_rs1_i = 5'd5; #1;
    total++; if (count_o !== 3'd0 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL basic_retire got=%0d/%b want=0/1", count_o, issue_ready_o); end
    idle();
  endtask

  task automatic test_raw_waw();
    do_issue(4'd1, 5'd7, 1'b1);
    set_issue(4'd2, 5'd7, 5'd0, 5'd8, 1'b1); issue_valid_i = 0; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL raw_rs1 got=%b want=0", issue_ready_o); end
    issue_rs1_i = 5'd0; issue_rs2_i = 5'd7; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL raw_rs2 got=%b want=0", issue_ready_o); end
    issue_rs2_i = 5'd0; issue_rd_i = 5'd7; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL waw_rd got=%b want=0", issue_ready_o); end
    issue_we_i = 1'b0; #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL waw_no_we got=%b want=1", issue_ready_o); end
    idle();
    do_commit(4'd1, 1'b0);
    issue_rs1_i = 5'd7; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL raw_committed got=%b want=0", issue_ready_o); end
    retire_valid_i = 1; retire_id_i = 4'd1; tick(); retire_valid_i = 0; #1;
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL raw_after_retire got=%b want=1", issue_ready_o); end
    idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) do_issue(4'(i), 5'(10 + i), 1'b1);
    #1;
    total++; if (count_o !== 3'd4 || issue_ready_o !== 1'b0) begin bad++; $display("FAIL fill_full got=%0d/%b want=4/0", count_o, issue_ready_o); end
    do_commit(4'd2, 1'b0);
    set_issue(4'd4, 5'd0, 5'd0, 5'd14, 1'b1);
    retire_valid_i = 1; retire_id_i = 4'd2; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL fill_retire_same_cycle got=%b want=0", issue_ready_o); end
    tick(); retire_valid_i = 0; #1;
    total++; if (count_o !== 3'd3 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL fill_freed got=%0d/%b want=3/1", count_o, issue_ready_o); end
    tick(); idle(); #1;
    total++; if (count_o !== 3'd4 || issue_ready_o !== 1'b0) begin bad++; $display("FAIL fill_accept_next got=%0d/%b want=4/0", count_o, issue_ready_o); end
    do_clear();
  endtask

  task automatic test_issue_kill();
    set_issue(4'd6, 5'd0, 5'd0, 5'd9, 1'b1);
    commit_valid_i = 1; commit_id_i = 4'd6; commit_kill_i = 1;
    tick(); idle();
    query_id_i = 4'd6; issue_rs1_i = 5'd9; #1;
    total++; if ({query_committed_o, query_killed_o} !== 2'b01) begin bad++; $display("FAIL kill_query got=%b want=01", {query_committed_o, query_killed_o}); end
    total++; if (count_o !== 3'd1 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL kill_no_pend got=%0d/%b want=1/1", count_o, issue_ready_o); end
`ifdef FIR_XIFU_CTRL_PERF_EN
    total++; if (kill_count_o !== 16'd1) begin bad++; $display("FAIL kill_count got=%0d want=1", kill_count_o); end
`endif
    idle(); do_retire(4'd6);
  endtask

  task automatic test_back_to_back();
    do_issue(4'd1, 5'd1, 1'b1);
    do_commit(4'd1, 1'b0);
    do_issue(4'd2, 5'd2, 1'b1);
    set_issue(4'd3, 5'd0, 5'd0, 5'd3, 1'b1);
    commit_valid_i = 1; commit_id_i = 4'd2;
    retire_valid_i = 1; retire_id_i = 4'd1;
    tick(); idle();
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", count_o); end
    query_id_i = 4'd2; #1;
    total++; if ({query_committed_o, query_killed_o} !== 2'b10) begin bad++; $display("FAIL b2b_commit got=%b want=10", {query_committed_o, query_killed_o}); end
    query_id_i = 4'd1; #1;
    total++; if ({query_committed_o, query_killed_o} !== 2'b00) begin bad++; $display("FAIL b2b_retired got=%b want=00", {query_committed_o, query_killed_o}); end
    issue_rs1_i = 5'd3; #1;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_new_pend got=%b want=0", issue_ready_o); end
    idle(); do_clear();
  endtask

  task automatic test_clear();
    do_issue(4'd8, 5'd20, 1'b1);
    do_issue(4'd9, 5'd21, 1'b1);
    do_issue(4'd10, 5'd22, 1'b1);
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL clear_pre got=%0d want=3", count_o); end
    set_issue(4'd11, 5'd0, 5'd0, 5'd23, 1'b1); clear_i = 1;
    tick(); idle();
    set_issue(4'd12, 5'd20, 5'd21, 5'd22, 1'b1); issue_valid_i = 0; query_id_i = 4'd8; #1;
    total++; if (count_o !== 3'd0 || busy_o !== 1'b0) begin bad++; $display("FAIL clear_empty got=%0d/%b want=0/0", count_o, busy_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL clear_scoreboard got=%b want=1", issue_ready_o); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_issue(4'd1, 5'd1, 1'b1);
    do_issue(4'd2, 5'd2, 1'b1);
    set_issue(4'd3, 5'd0, 5'd0, 5'd3, 1'b1);
    commit_valid_i = 1; commit_id_i = 4'd1; rst_i = 1;
    tick(); rst_i = 0; idle(); query_id_i = 4'd1; #1;
    total++; if (count_o !== 3'd0 || busy_o !== 1'b0 || issue_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_state got=%0d/%b/%b want=0/0/1", count_o, busy_o, issue_ready_o); end
    total++; if ({query_committed_o, query_killed_o} !== 2'b00) begin bad++; $display("FAIL rstmid_query got=%b want=00", {query_committed_o, query_killed_o}); end
`ifdef FIR_XIFU_CTRL_PERF_EN
    total++; if (kill_count_o !== 16'd0 || stall_cycles_o !== 32'd0) begin bad++; $display("FAIL rstmid_perf got=%0d/%0d want=0/0", stall_cycles_o, kill_count_o); end
    do_issue(4'd1, 5'd4, 1'b1);
    set_issue(4'd2, 5'd4, 5'd0, 5'd5, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    idle(); #1;
    total++; if (stall_cycles_o !== 32'd3) begin bad++; $display("FAIL stall_count got=%0d want=3", stall_cycles_o); end
`endif
    idle();
  endtask

  initial begin
    idle(); rst_i = 1;
    test_reset();
    test_basic();
    test_raw_waw();
    test_fill();
    test_issue_kill();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_xifu_ctrl.md
# fir_xifu_ctrl

In-flight instruction controller for the FIR XIFU coprocessor. It sits beside the ID stage on the X-interface issue/commit path and tracks every accepted XIFU instruction until the pipeline retires it. It gates `issue_ready` on table occupancy and on XIFU register-file RAW/WAW hazards. It also tells the EX/WB stages whether a given instruction ID has been committed or killed.

## Interface
- `DEPTH`, default 4: number of in-flight entries (power of two, ≥2).
- `ID_WIDTH`, default 4: X-interface instruction ID width.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `clear_i` in 1: synchronous flush of all entries.
- `issue_valid_i` in 1: X-interface issue request valid.
- `issue_accept_i` in 1: the decoder accepts the request as an XIFU instruction.
- `issue_id_i` in `ID_WIDTH`: ID of the instruction being issued.
- `issue_rs1_i`, `issue_rs2_i`, `issue_rd_i` in 5 each: XIFU register indices.
- `issue_we_i` in 1: the instruction writes XIFU register `rd`.
- `issue_ready_o` out 1: the controller can take the request.
- `commit_valid_i` in 1: commit valid.
- `commit_id_i` in `ID_WIDTH`: ID being committed.
- `commit_kill_i` in 1: kill instead of commit.
- `retire_valid_i` in 1: the WB stage finished an instruction.
- `retire_id_i` in `ID_WIDTH`: ID of the retired instruction.
- `query_id_i` in `ID_WIDTH`: ID looked up by EX.
- `query_committed_o` out 1: the queried entry is COMMITTED.
- `query_killed_o` out 1: the queried entry is KILLED.
- `busy_o` out 1: at least one entry is valid.
- `count_o` out `$clog2(DEPTH)+1`: number of valid entries.
- `stall_cycles_o` out 32: present only with the performance macro (see Configuration).
- `kill_count_o` out 16: present only with the performance macro (see Configuration).

## Operation
- Each entry holds: state (FREE, ISSUED, COMMITTED, KILLED), `id`, `rd`, `we`.
- **Issue handshake:** `issue_valid_i & issue_accept_i & issue_ready_o`. The lowest-index FREE entry is allocated in state ISSUED.
- **Commit, same cycle as issue:** if `commit_valid_i` arrives in the same cycle with `commit_id_i == issue_id_i`, the new entry is written directly as COMMITTED, or KILLED if `commit_kill_i` is set.
- **Commit, later:** `commit_valid_i` on a matching ISSUED entry moves it to COMMITTED, or to KILLED if `commit_kill_i` is set. A commit for an unmatched ID is ignored.
- **Retire:** `retire_valid_i` on a matching COMMITTED or KILLED entry moves it to FREE. A retire for an ISSUED entry or an unknown ID is a protocol error; it is ignored and flagged by an assertion.
- **Pending-write scoreboard:** a 32-bit vector, the OR of `1<<rd` over ISSUED and COMMITTED entries with `we`. KILLED entries do not count.
- **`issue_ready_o`** is the AND of:
  - `count_o < DEPTH`;
  - `rs1`, `rs2` and `rd` (when `issue_we_i`) are not pending.
- `issue_ready_o` depends on registered state and the issue fields only, never on commit or retire inputs.
- Query outputs decode registered state only. An unmatched `query_id_i` gives 0/0.
- IDs are unique among valid entries; an assertion checks this.
- Priority: `rst_i` > `clear_i` > normal operation. `clear_i` frees all entries and clears the scoreboard.

## Timing
- Reset values:
  - `issue_ready_o` = 1 (empty table, no hazard);
  - `busy_o` = 0, `count_o` = 0;
  - query outputs = 0;
  - counters = 0.
- An issue handshake in cycle N makes the entry and its scoreboard bit visible in N+1.
- A commit in N is seen on the query outputs in N+1.
- A retire in N frees the entry in N+1. `issue_ready_o` may reassert in N+1; there is no same-cycle reuse of a freed entry.
- Issue, commit of another ID, and retire of a third ID may all occur in one cycle. All three are applied, and `count_o` nets +1, 0 or −1.
- Full table: `issue_ready_o` = 0 while `count_o == DEPTH`.
- Reset or clear mid-operation: all entries FREE in the next cycle, regardless of concurrent issue, commit or retire.

## Configuration
- `FIR_XIFU_CTRL_PERF_EN` defined:
  - `stall_cycles_o` counts cycles with `issue_valid_i & issue_accept_i & ~issue_ready_o`, saturating at 2^32−1.
  - `kill_count_o` counts transitions into KILLED, saturating at 2^16−1.
  - Both are cleared by `rst_i` only.
- Macro undefined: both ports are absent and the logic is not built.

## Structure
- Shared package `fir_xifu_pkg` gets:
  - `fir_xifu_ctrl_state_e` (FREE/ISSUED/COMMITTED/KILLED);
  - `fir_xifu_ctrl_entry_t` (state, id, rd, we);
  - `FIR_XIFU_NREGS = 32`.
- Sub-module `fir_xifu_ctrl_slot`, instantiated `DEPTH` times. It holds one entry's state machine and its ID-match comparators for commit, retire and query.
- The top level owns allocation (lowest-free priority encoder), the scoreboard OR-reduction, the count and the counters.

## Test plan
- **Basic flow:** issue ID 3 (rd=5, we=1) → `count_o`=1 and bit 5 pending. Commit ID 3 → query ID 3 committed=1. Retire ID 3 → `count_o`=0 and `issue_ready_o`=1.
- **RAW hazard:** ID 1 in flight writing rd=7. Issue with rs1=7 → `issue_ready_o`=0. Retire ID 1 → ready in the next cycle.
- **Fill and same-cycle retire:** issue IDs 0–3 → `issue_ready_o`=0 at `count_o`=4. Retire ID 2 alongside an issue request → request stalls that cycle and is accepted the next.
- **Same-cycle issue and kill:** issue ID 6 with `commit_valid_i`, `commit_id_i`=6, `commit_kill_i`=1 → next cycle query killed=1 and no scoreboard bit set; `kill_count_o`=1 with the macro.
- **Clear:** 3 entries in flight, `clear_i` pulse → `count_o`=0, `busy_o`=0, all scoreboard bits 0. Reset asserted mid-issue → all outputs at reset values.
